// File: rtl/mips64_multicycle_ctrl.sv
// Multi-cycle control FSM for the 64-bit MIPS datapath: decodes IR opcode/funct and sequences
// FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, stalling on mem_ready; counts retirements, flags illegal ops.
module mips64_multicycle_ctrl #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           opcode,
    input  logic [5:0]           funct,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 pc_write_cond,
    output logic                 iord,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 reg_dst,
    output logic                 mem_to_reg,
    output logic                 reg_write,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic [1:0]           pc_source,
    output logic [3:0]           state,
    output logic                 retire,
    output logic [CNT_WIDTH-1:0] instr_count,
    output logic                 illegal_op
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_EXEC_R  = 4'd2,
        S_WB_R    = 4'd3,
        S_EXEC_I  = 4'd4,
        S_WB_I    = 4'd5,
        S_ADDR    = 4'd6,
        S_MEM_RD  = 4'd7,
        S_WB_MEM  = 4'd8,
        S_MEM_WR  = 4'd9,
        S_BRANCH  = 4'd10,
        S_JUMP    = 4'd11,
        S_ILLEGAL = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_DADDI = 6'b011000;
    localparam logic [5:0] OP_LD    = 6'b110111;
    localparam logic [5:0] OP_SD    = 6'b111111;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t cur;
    state_t dec_next;
    logic   funct_ok;

    // The branch decision is made in the datapath from pc_write_cond and zero.
    logic unused_zero;
    assign unused_zero = zero;

    assign state = cur;

    always_comb begin
        funct_ok = (funct == 6'b101100) || (funct == 6'b101110) || (funct == 6'b100100) ||
                   (funct == 6'b100101) || (funct == 6'b101010);
        case (opcode)
            OP_RTYPE:    dec_next = funct_ok ? S_EXEC_R : S_ILLEGAL;
            OP_DADDI:    dec_next = S_EXEC_I;
            OP_LD, OP_SD: dec_next = S_ADDR;
            OP_BEQ:      dec_next = S_BRANCH;
            OP_J:        dec_next = S_JUMP;
            default:     dec_next = S_ILLEGAL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur         <= S_FETCH;
            instr_count <= '0;
            illegal_op  <= 1'b0;
        end else begin
            if (retire)
                instr_count <= instr_count + CNT_WIDTH'(1);
            case (cur)
                S_FETCH:  if (mem_ready) cur <= S_DECODE;
                S_DECODE: begin
                    cur <= dec_next;
                    if (dec_next == S_ILLEGAL)
                        illegal_op <= 1'b1;
                end
                S_EXEC_R: cur <= S_WB_R;
                S_EXEC_I: cur <= S_WB_I;
                S_ADDR:   cur <= (opcode == OP_LD) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD: if (mem_ready) cur <= S_WB_MEM;
                S_MEM_WR: if (mem_ready) cur <= S_FETCH;
                default:  cur <= S_FETCH;
            endcase
        end
    end

    // Gated by rst so nothing is strobed while reset is held, even though FETCH is the reset state.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        retire        = 1'b0;
        if (!rst) begin
            case (cur)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    pc_write  = mem_ready;
                    ir_write  = mem_ready;
                end
                S_DECODE: alu_src_b = 2'b11;
                S_EXEC_R: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                S_WB_R: begin
                    reg_dst   = 1'b1;
                    reg_write = 1'b1;
                    retire    = 1'b1;
                end
                S_EXEC_I, S_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_WB_I: begin
                    reg_write = 1'b1;
                    retire    = 1'b1;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                S_WB_MEM: begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                    retire     = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                    retire    = mem_ready;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                    retire        = 1'b1;
                end
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                    retire    = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
